// File: rtl/tile_request_sender_pkg.sv
// ============================================================================
// tile_request_sender_pkg: word type codes, buffer word layout, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package tile_request_sender_pkg;

  // Type codes of the tile-request word protocol, also decoded by the solver manager.
  typedef enum logic [2:0] {
    WT_ADDR  = 3'd0,
    WT_ZOOM  = 3'd1,
    WT_REAL  = 3'd2,
    WT_IMAG  = 3'd3,
    WT_START = 3'd4
  } word_type_e;

  typedef struct packed {
    word_type_e  kind;
    logic [31:0] payload;
  } word_t;

  localparam int WORD_BITS = $bits(word_t);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_ZOOM = 3'd1,
    ST_RD_REAL  = 3'd2,
    ST_RD_IMAG  = 3'd3,
    ST_START    = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  function automatic word_t make_word(input word_type_e kind, input logic [31:0] payload);
    word_t w;
    w.kind    = kind;
    w.payload = payload;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_request_sender_if.sv
// ============================================================================
// tile_request_sender_if: request, limb-memory and output-word signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tile_request_sender_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27
);
  logic                       req_valid;
  logic                       req_ready;
  logic [31:0]                req_output_addr;
  logic [31:0]                req_zoom_level;
  logic [LIMB_INDEX_BITS:0]   req_num_limbs;
  logic                       limb_rd_en;
  logic                       limb_rd_imag;
  logic [LIMB_INDEX_BITS-1:0] limb_rd_addr;
  logic [LIMB_SIZE_BITS-1:0]  limb_rd_data;
  logic                       fifo_valid;
  logic                       fifo_ready;
  logic [2:0]                 fifo_data_type;
  logic [31:0]                fifo_data;
  logic                       busy;

  modport master (
    input  req_valid, req_output_addr, req_zoom_level, req_num_limbs,
           limb_rd_data, fifo_ready,
    output req_ready, limb_rd_en, limb_rd_imag, limb_rd_addr,
           fifo_valid, fifo_data_type, fifo_data, busy
  );

  modport slave (
    output req_valid, req_output_addr, req_zoom_level, req_num_limbs,
           limb_rd_data, fifo_ready,
    input  req_ready, limb_rd_en, limb_rd_imag, limb_rd_addr,
           fifo_valid, fifo_data_type, fifo_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/tile_request_sender_skid_buffer.sv
// ============================================================================
// typed_word_skid_buffer: 2-entry FIFO of typed 35-bit words, registered head
// Revision: 1.0
// ============================================================================
`default_nettype none

module typed_word_skid_buffer
  import tile_request_sender_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid_i,
  input  word_t      in_word_i,
  output logic       out_valid_o,
  output word_t      out_word_o,
  input  logic       out_ready_i,
  output logic [1:0] count_o
);

  word_t      head_q, head_d;
  word_t      tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop;
  logic       push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop     = out_ready_i && (count_q != 2'd0);
    push    = in_valid_i && ((count_q != 2'd2) || pop);
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_word_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_word_i;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (push) begin
          tail_d  = in_word_i;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = in_word_i;
          else      count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_word_o  = head_q;
  assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/tile_request_sender.sv
// ============================================================================
// tile_request_sender: serialises a tile request (header, limbs, start) into typed words
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_request_sender
  import tile_request_sender_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27
) (
  input logic                   clock,
  input logic                   reset,
  tile_request_sender_if.master bus
);

  localparam int CNT_BITS = LIMB_INDEX_BITS + 1;

  state_e                     state_q, state_d;
  logic [31:0]                zoom_q, zoom_d;
  logic [CNT_BITS-1:0]        num_q, num_d;
  logic [CNT_BITS-1:0]        idx_q, idx_d;
  logic [CNT_BITS-1:0]        idx_next;
  logic                       inflight_q, inflight_imag_q;

  logic                       push;
  word_t                      push_word;
  logic                       rd_en;
  logic                       rd_imag;
  logic [LIMB_INDEX_BITS-1:0] rd_addr;
  logic                       buf_valid;
  word_t                      buf_word;
  logic [1:0]                 buf_count;
  logic                       pop;
  logic                       accept;
  logic [2:0]                 occ;

  typed_word_skid_buffer u_buf (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (push),
    .in_word_i   (push_word),
    .out_valid_o (buf_valid),
    .out_word_o  (buf_word),
    .out_ready_i (bus.fifo_ready),
    .count_o     (buf_count)
  );

  assign bus.req_ready      = !reset && (state_q == ST_IDLE) && (buf_count == 2'd0);
  assign bus.fifo_valid     = buf_valid && !reset;
  assign bus.fifo_data_type = buf_word.kind;
  assign bus.fifo_data      = buf_word.payload;
  assign bus.busy           = !reset && (state_q != ST_IDLE);
  assign bus.limb_rd_en     = rd_en && !reset;
  assign bus.limb_rd_imag   = rd_imag;
  assign bus.limb_rd_addr   = rd_addr;

  assign pop      = bus.fifo_valid && bus.fifo_ready;
  assign accept   = bus.req_valid && bus.req_ready;
  // Slots already claimed next cycle: stored words plus returning read data, minus the word leaving now.
  assign occ      = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign idx_next = idx_q + CNT_BITS'(1);

  always_comb begin
    state_d   = state_q;
    zoom_d    = zoom_q;
    num_d     = num_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_word = '0;
    rd_en     = 1'b0;
    rd_imag   = 1'b0;
    rd_addr   = '0;

    if (inflight_q) begin
      push      = 1'b1;
      push_word = make_word(inflight_imag_q ? WT_IMAG : WT_REAL, 32'(bus.limb_rd_data));
    end

    case (state_q)
      ST_IDLE: begin
        // The address word is written on the accepting edge so it is presented the very next cycle.
        if (accept) begin
          zoom_d    = bus.req_zoom_level;
          num_d     = bus.req_num_limbs;
          idx_d     = '0;
          push      = 1'b1;
          push_word = make_word(WT_ADDR, bus.req_output_addr);
          state_d   = ST_HDR_ZOOM;
        end
      end
      ST_HDR_ZOOM: begin
        if (occ < 3'd2) begin
          push      = 1'b1;
          push_word = make_word(WT_ZOOM, zoom_q);
          if (num_q == '0) begin
            state_d = ST_START;
          end else if (occ == 3'd0) begin
            // Room for both: launch limb 0 alongside the zoom word to avoid a bubble.
            rd_en = 1'b1;
            if (num_q == CNT_BITS'(1)) begin
              idx_d   = '0;
              state_d = ST_RD_IMAG;
            end else begin
              idx_d   = CNT_BITS'(1);
              state_d = ST_RD_REAL;
            end
          end else begin
            idx_d   = '0;
            state_d = ST_RD_REAL;
          end
        end
      end
      ST_RD_REAL, ST_RD_IMAG: begin
        if (occ < 3'd2) begin
          rd_en   = 1'b1;
          rd_imag = (state_q == ST_RD_IMAG);
          rd_addr = idx_q[LIMB_INDEX_BITS-1:0];
          if (idx_next == num_q) begin
            idx_d   = '0;
            state_d = (state_q == ST_RD_REAL) ? ST_RD_IMAG : ST_START;
          end else begin
            idx_d = idx_next;
          end
        end
      end
      ST_START: begin
        if (!inflight_q && (occ < 3'd2)) begin
          push      = 1'b1;
          push_word = make_word(WT_START, 32'd0);
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((buf_count == 2'd1) && pop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      zoom_q          <= '0;
      num_q           <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_imag_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      zoom_q          <= zoom_d;
      num_q           <= num_d;
      idx_q           <= idx_d;
      inflight_q      <= rd_en;
      inflight_imag_q <= rd_imag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_request_sender.sv
// ============================================================================
// tb_tile_request_sender: word-queue model of tile_request_sender with directed requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tile_request_sender;

  localparam int LIB = 6;
  localparam int LSB = 27;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tile_request_sender_if #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB)) bus();

  tile_request_sender #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [26:0] real_mem [64];
  logic [26:0] imag_mem [64];

  always @(posedge clock)
    if (bus.limb_rd_en)
      bus.limb_rd_data <= bus.limb_rd_imag ? imag_mem[bus.limb_rd_addr] : real_mem[bus.limb_rd_addr];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [34:0] exp_q [$];
  logic [6:0]  rd_q  [$];
  int          log_type [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];
  int          rd_pulses    = 0;
  int          accepted_cnt = 0;
  int          accept_cyc   = 0;
  int          ready_mode   = 0;
  logic        prev_stall   = 1'b0;
  logic [34:0] prev_word    = '0;
  logic        was_reset    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Model: every accepted request expands into its complete word list and read list.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_fifo_valid", bus.fifo_valid, 0);
      chk("rst_limb_rd_en", bus.limb_rd_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      exp_q.delete();
      rd_q.delete();
      prev_stall = 1'b0;
      was_reset  = 1'b1;
    end else begin
      if (was_reset) chk("post_rst_req_ready", bus.req_ready, 1);
      was_reset = 1'b0;
      chk("req_ready", bus.req_ready, exp_q.size() == 0);
      chk("busy", bus.busy, exp_q.size() != 0);
      if (prev_stall) chk("stable_word", {bus.fifo_data_type, bus.fifo_data}, prev_word);
      if (bus.fifo_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", {bus.fifo_data_type, bus.fifo_data}, 64'hDEAD);
        end else begin
          chk("word", {bus.fifo_data_type, bus.fifo_data}, exp_q[0]);
          if (bus.fifo_ready) begin
            if (exp_q[0][34:32] == 3'd4) chk("reads_done_at_start", rd_q.size(), 0);
            void'(exp_q.pop_front());
          end
        end
        if (bus.fifo_ready) begin
          log_type.push_back(int'(bus.fifo_data_type));
          log_data.push_back(bus.fifo_data);
          log_cyc.push_back(cyc);
        end
      end
      prev_stall = bus.fifo_valid && !bus.fifo_ready;
      prev_word  = {bus.fifo_data_type, bus.fifo_data};
      if (bus.limb_rd_en) begin
        rd_pulses++;
        if (rd_q.size() == 0) chk("spurious_read", {bus.limb_rd_imag, bus.limb_rd_addr}, 64'hDEAD);
        else begin
          chk("read_addr", {bus.limb_rd_imag, bus.limb_rd_addr}, rd_q[0]);
          void'(rd_q.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        int n;
        n = int'(bus.req_num_limbs);
        accepted_cnt++;
        accept_cyc = cyc;
        exp_q.push_back({3'd0, bus.req_output_addr});
        exp_q.push_back({3'd1, bus.req_zoom_level});
        for (int i = 0; i < n; i++) exp_q.push_back({3'd2, 5'd0, real_mem[i]});
        for (int i = 0; i < n; i++) exp_q.push_back({3'd3, 5'd0, imag_mem[i]});
        exp_q.push_back({3'd4, 32'd0});
        for (int i = 0; i < n; i++) rd_q.push_back({1'b0, 6'(i)});
        for (int i = 0; i < n; i++) rd_q.push_back({1'b1, 6'(i)});
      end
    end
  end

  initial begin
    bus.fifo_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.fifo_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    log_type.delete();
    log_data.delete();
    log_cyc.delete();
    rd_pulses = 0;
  endtask

  task automatic wait_accept(input int target, input string name);
    int t = 0;
    while (accepted_cnt < target && t < 2000) begin
      tick();
      t++;
    end
    chk({name, "_accepted"}, accepted_cnt >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [31:0] zoom, input int n);
    bus.req_output_addr = addr;
    bus.req_zoom_level  = zoom;
    bus.req_num_limbs   = 7'(n);
  endtask

  task automatic do_request(input logic [31:0] addr, input logic [31:0] zoom, input int n, input string name);
    int target;
    clear_log();
    target = accepted_cnt + 1;
    set_req(addr, zoom, n);
    bus.req_valid = 1'b1;
    wait_accept(target, name);
    bus.req_valid = 1'b0;
    set_req($urandom, $urandom, int'($urandom_range(0, 64)));
    wait_idle(name);
    tick();
    tick();
  endtask

  task automatic chk_log(input string name, input int i, input int t, input logic [31:0] d);
    if (i < log_type.size()) chk($sformatf("%s[%0d]", name, i), {3'(log_type[i]), log_data[i]}, {3'(t), d});
    else chk($sformatf("%s_len", name), log_type.size(), i + 1);
  endtask

  initial begin
    int cnt2, cnt3, bad, target;
    bus.req_valid = 1'b0;
    set_req(32'd0, 32'd0, 0);
    for (int i = 0; i < 64; i++) begin
      real_mem[i] = '0;
      imag_mem[i] = '0;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_fifo_valid", bus.fifo_valid, 0);

    // Two limbs per component, full-rate sink.
    real_mem[0] = 27'h11; real_mem[1] = 27'h22;
    imag_mem[0] = 27'h33; imag_mem[1] = 27'h44;
    do_request(32'h1000, 32'd5, 2, "t034");
    chk("t034_len", log_type.size(), 7);
    chk_log("t034", 0, 0, 32'h1000);
    chk_log("t034", 1, 1, 32'd5);
    chk_log("t034", 2, 2, 32'h11);
    chk_log("t034", 3, 2, 32'h22);
    chk_log("t034", 4, 3, 32'h33);
    chk_log("t034", 5, 3, 32'h44);
    chk_log("t034", 6, 4, 32'd0);
    if (log_cyc.size() == 7) begin
      chk("t034_first_latency", log_cyc[0] - accept_cyc, 1);
      for (int i = 1; i < 7; i++) chk("t034_back_to_back", log_cyc[i] - log_cyc[0], i);
    end

    // No limbs: header and start only.
    do_request(32'hABCD, 32'd1, 0, "t035");
    chk("t035_len", log_type.size(), 3);
    chk_log("t035", 0, 0, 32'hABCD);
    chk_log("t035", 1, 1, 32'd1);
    chk_log("t035", 2, 4, 32'd0);
    chk("t035_no_reads", rd_pulses, 0);

    // Stalling sink, ready pattern 1,0,0,1.
    for (int i = 0; i < 3; i++) begin
      real_mem[i] = 27'(32'h101 + i);
      imag_mem[i] = 27'(32'h201 + i);
    end
    ready_mode = 1;
    do_request(32'h5555, 32'd7, 3, "t036");
    chk("t036_len", log_type.size(), 9);
    chk_log("t036", 2, 2, 32'h101);
    chk_log("t036", 4, 2, 32'h103);
    chk_log("t036", 5, 3, 32'h201);
    chk_log("t036", 8, 4, 32'd0);

    // Full-size component with all-ones limbs.
    for (int i = 0; i < 64; i++) begin
      real_mem[i] = 27'h7FFFFFF;
      imag_mem[i] = 27'h7FFFFFF;
    end
    do_request(32'h0BAD_F00D, 32'd12, 64, "t037");
    cnt2 = 0; cnt3 = 0; bad = 0;
    foreach (log_type[i]) begin
      if (log_type[i] == 2) cnt2++;
      if (log_type[i] == 3) cnt3++;
      if ((log_type[i] == 2 || log_type[i] == 3) && log_data[i] != 32'h07FFFFFF) bad++;
    end
    chk("t037_len", log_type.size(), 131);
    chk("t037_real_words", cnt2, 64);
    chk("t037_imag_words", cnt3, 64);
    chk("t037_payload_bad", bad, 0);
    chk("t037_read_pulses", rd_pulses, 128);
    chk_log("t037", 129, 3, 32'h07FFFFFF);
    ready_mode = 0;

    // Reset after the third word, then a clean one-limb request.
    clear_log();
    target = accepted_cnt + 1;
    set_req(32'h7777, 32'd4, 4);
    bus.req_valid = 1'b1;
    wait_accept(target, "t038a");
    bus.req_valid = 1'b0;
    for (int t = 0; t < 200 && log_type.size() < 3; t++) tick();
    chk("t038_three_words", log_type.size() >= 3, 1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    real_mem[0] = 27'h5A;
    imag_mem[0] = 27'h6B;
    do_request(32'h2222, 32'd9, 1, "t038b");
    chk("t038_len", log_type.size(), 5);
    chk_log("t038", 0, 0, 32'h2222);
    chk_log("t038", 1, 1, 32'd9);
    chk_log("t038", 2, 2, 32'h5A);
    chk_log("t038", 3, 3, 32'h6B);
    chk_log("t038", 4, 4, 32'd0);

    // Second request held valid while the first is in progress.
    real_mem[1] = 27'h77;
    imag_mem[1] = 27'h88;
    clear_log();
    target = accepted_cnt + 1;
    set_req(32'h3000, 32'd2, 1);
    bus.req_valid = 1'b1;
    wait_accept(target, "t039a");
    set_req(32'h4000, 32'd3, 2);
    wait_accept(target + 1, "t039b");
    bus.req_valid = 1'b0;
    wait_idle("t039");
    chk("t039_len", log_type.size(), 12);
    chk_log("t039", 0, 0, 32'h3000);
    chk_log("t039", 4, 4, 32'd0);
    chk_log("t039", 5, 0, 32'h4000);
    chk_log("t039", 8, 2, 32'h77);
    chk_log("t039", 11, 4, 32'd0);
    if (log_cyc.size() == 12) chk("t039_order", log_cyc[5] > log_cyc[4], 1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
